// File: rtl/riscv_rf_wb_arbiter.sv
// Writeback arbiter: merges EX, LSU and buffered long-latency results onto two RF write ports.
// Optional macro RF_WB_BYPASS_EN: same-cycle bypass of long-latency results around an empty FIFO.
module riscv_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int FPU        = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          setback_i,
    input  logic                          ex_we_i,
    input  logic [ADDR_WIDTH-1:0]         ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]         ex_wdata_i,
    input  logic                          lsu_we_i,
    input  logic [ADDR_WIDTH-1:0]         lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]         lsu_wdata_i,
    input  logic                          mc_valid_i,
    output logic                          mc_ready_o,
    input  logic [ADDR_WIDTH-1:0]         mc_waddr_i,
    input  logic [DATA_WIDTH-1:0]         mc_wdata_i,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_a_o,
    output logic [ADDR_WIDTH-1:0]         waddr_b_o,
    output logic [DATA_WIDTH-1:0]         wdata_b_o,
    output logic                          we_b_o,
    output logic [2**ADDR_WIDTH-1:0]      pending_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  fifo_empty, head_to_a, head_to_b, pop, push;
    logic                  byp_a, byp_b;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_empty = (cnt_q == '0);
    assign head_addr  = mem_addr_q[rd_ptr_q];
    assign head_data  = mem_data_q[rd_ptr_q];

    // The head drains on B first; A only gets it when B is owned by the LSU.
    assign head_to_b = !setback_i && !fifo_empty && !lsu_we_i;
    assign head_to_a = !setback_i && !fifo_empty && !ex_we_i && !head_to_b;
    assign pop       = head_to_a || head_to_b;

`ifdef RF_WB_BYPASS_EN
    assign byp_b = !setback_i && fifo_empty && mc_valid_i && !lsu_we_i;
    assign byp_a = !setback_i && fifo_empty && mc_valid_i && lsu_we_i && !ex_we_i;
`else
    assign byp_b = 1'b0;
    assign byp_a = 1'b0;
`endif

    assign mc_ready_o = !setback_i && ((cnt_q < CNT_W'(FIFO_DEPTH)) || pop);
    assign push       = mc_valid_i && mc_ready_o && !byp_a && !byp_b;
    assign fifo_cnt_o = cnt_q;

    always_comb begin
        we_a_o    = 1'b0;
        waddr_a_o = '0;
        wdata_a_o = '0;
        we_b_o    = 1'b0;
        waddr_b_o = '0;
        wdata_b_o = '0;
        if (!setback_i) begin
            if (ex_we_i) begin
                we_a_o = 1'b1; waddr_a_o = ex_waddr_i; wdata_a_o = ex_wdata_i;
            end else if (head_to_a) begin
                we_a_o = 1'b1; waddr_a_o = head_addr;  wdata_a_o = head_data;
            end else if (byp_a) begin
                we_a_o = 1'b1; waddr_a_o = mc_waddr_i; wdata_a_o = mc_wdata_i;
            end
            if (lsu_we_i) begin
                we_b_o = 1'b1; waddr_b_o = lsu_waddr_i; wdata_b_o = lsu_wdata_i;
            end else if (head_to_b) begin
                we_b_o = 1'b1; waddr_b_o = head_addr;   wdata_b_o = head_data;
            end else if (byp_b) begin
                we_b_o = 1'b1; waddr_b_o = mc_waddr_i;  wdata_b_o = mc_wdata_i;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (setback_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= mc_waddr_i;
            mem_data_q[wr_ptr_q] <= mc_wdata_i;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [ADDR_WIDTH-1:0] slot_idx [FIFO_DEPTH];
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offs;
            assign offs           = PTR_W'(gi) - rd_ptr_q;
            assign slot_valid[gi] = ({1'b0, offs} < cnt_q);
            if (FPU != 0) begin : g_fp
                assign slot_idx[gi] = mem_addr_q[gi];
            end else begin : g_int
                assign slot_idx[gi] = {1'b0, mem_addr_q[gi][ADDR_WIDTH-2:0]};
            end
        end
    endgenerate

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i]) pending_o[slot_idx[i]] = 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Bench for riscv_rf_wb_arbiter: queue-based model checked every negedge plus directed literal checks.
module tb_riscv_rf_wb_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int FPU = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          setback_i;
    logic          ex_we_i, lsu_we_i, mc_valid_i;
    logic [AW-1:0] ex_waddr_i, lsu_waddr_i, mc_waddr_i;
    logic [DW-1:0] ex_wdata_i, lsu_wdata_i, mc_wdata_i;
    logic          mc_ready_o, we_a_o, we_b_o;
    logic [AW-1:0] waddr_a_o, waddr_b_o;
    logic [DW-1:0] wdata_a_o, wdata_b_o;
    logic [63:0]   pending_o;
    logic [2:0]    fifo_cnt_o;

    int checks = 0;
    int failures = 0;

    riscv_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FPU(FPU)) dut (
        .clk(clk), .rst_n(rst_n), .setback_i(setback_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
        .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i),
        .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
        .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
        .pending_o(pending_o), .fifo_cnt_o(fifo_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue of (addr, data) in arrival order.
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } entry_t;
    entry_t q[$];

    always @(negedge clk) begin : model
        logic          e_we_a, e_we_b, e_rdy, do_pop, do_push, byp;
        logic [AW-1:0] e_wa_a, e_wa_b;
        logic [DW-1:0] e_wd_a, e_wd_b;
        logic [63:0]   e_pend;
        if (!rst_n) begin
            q.delete();
        end else begin
            e_we_a = 0; e_wa_a = 0; e_wd_a = 0;
            e_we_b = 0; e_wa_b = 0; e_wd_b = 0;
            do_pop = 0; byp = 0;
            e_pend = 0;
            foreach (q[i]) e_pend[(FPU != 0) ? q[i].a : {1'b0, q[i].a[AW-2:0]}] = 1'b1;
            if (!setback_i) begin
                if (lsu_we_i) begin
                    e_we_b = 1; e_wa_b = lsu_waddr_i; e_wd_b = lsu_wdata_i;
                end else if (q.size() > 0) begin
                    e_we_b = 1; e_wa_b = q[0].a; e_wd_b = q[0].d; do_pop = 1;
                end
                if (ex_we_i) begin
                    e_we_a = 1; e_wa_a = ex_waddr_i; e_wd_a = ex_wdata_i;
                end else if (q.size() > 0 && !do_pop) begin
                    e_we_a = 1; e_wa_a = q[0].a; e_wd_a = q[0].d; do_pop = 1;
                end
`ifdef RF_WB_BYPASS_EN
                if (q.size() == 0 && mc_valid_i) begin
                    if (!e_we_b) begin
                        e_we_b = 1; e_wa_b = mc_waddr_i; e_wd_b = mc_wdata_i; byp = 1;
                    end else if (!e_we_a) begin
                        e_we_a = 1; e_wa_a = mc_waddr_i; e_wd_a = mc_wdata_i; byp = 1;
                    end
                end
`endif
            end
            e_rdy   = !setback_i && (q.size() < DEPTH || do_pop);
            do_push = mc_valid_i && e_rdy && !byp;
            chk("m_we_a", we_a_o, e_we_a);
            chk("m_waddr_a", waddr_a_o, e_wa_a);
            chk("m_wdata_a", wdata_a_o, e_wd_a);
            chk("m_we_b", we_b_o, e_we_b);
            chk("m_waddr_b", waddr_b_o, e_wa_b);
            chk("m_wdata_b", wdata_b_o, e_wd_b);
            chk("m_ready", mc_ready_o, e_rdy);
            chk("m_cnt", fifo_cnt_o, q.size());
            chk("m_pending", pending_o, e_pend);
            if (setback_i) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{a: mc_waddr_i, d: mc_wdata_i});
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        setback_i = 0; ex_we_i = 0; lsu_we_i = 0; mc_valid_i = 0;
        ex_waddr_i = 0; lsu_waddr_i = 0; mc_waddr_i = 0;
        ex_wdata_i = 0; lsu_wdata_i = 0; mc_wdata_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 0;
        idle_inputs();
        step(); step(); settle();
        chk("rst_cnt", fifo_cnt_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_we_b", we_b_o, 0);
        step();
        rst_n = 1;
        step();

        // 1: EX write passes straight through on A
        ex_we_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEADBEEF;
        settle();
        chk("t1_we_a", we_a_o, 1);
        chk("t1_waddr_a", waddr_a_o, 5);
        chk("t1_wdata_a", wdata_a_o, 32'hDEADBEEF);
        chk("t1_we_b", we_b_o, 0);
        chk("t1_pending", pending_o, 0);
        step(); idle_inputs(); step();

        // 2: ports busy, fill FIFO, then drain on B in order
        ex_we_i = 1; lsu_we_i = 1; ex_waddr_i = 1; lsu_waddr_i = 2;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            mc_valid_i = 1; mc_waddr_i = AW'(7 + acc); mc_wdata_i = 100 + acc;
            settle();
            if (mc_ready_o) acc++;
            step();
        end
        chk("t2_accepts", acc, 4);
        mc_valid_i = 0;
        settle();
        chk("t2_ready", mc_ready_o, 0);
        chk("t2_cnt", fifo_cnt_o, 4);
        chk("t2_pending", pending_o, 64'h780);
        step();
        lsu_we_i = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_drain_we_b", we_b_o, 1);
            chk("t2_drain_addr", waddr_b_o, 7 + i);
            chk("t2_drain_data", wdata_b_o, 100 + i);
            step();
        end
        idle_inputs(); step();

        // 3: LSU busy, EX idle -> head goes to A
        ex_we_i = 1; lsu_we_i = 1; mc_valid_i = 1; mc_waddr_i = 3; mc_wdata_i = 32'h33;
        step();
        mc_valid_i = 0; ex_we_i = 0;
        settle();
        chk("t3_we_a", we_a_o, 1);
        chk("t3_waddr_a", waddr_a_o, 3);
        chk("t3_wdata_a", wdata_a_o, 32'h33);
        chk("t3_cnt", fifo_cnt_o, 1);
        chk("t3_pend3", pending_o[3], 1);
        step(); settle();
        chk("t3_cnt_after", fifo_cnt_o, 0);
        chk("t3_pend_after", pending_o, 0);
        idle_inputs(); step();

        // 4: full FIFO with simultaneous push/pop across three wraps
        ex_we_i = 1; lsu_we_i = 1;
        for (int i = 0; i < 4; i++) begin
            mc_valid_i = 1; mc_waddr_i = AW'(16 + i); mc_wdata_i = 32'h400 + i;
            step();
        end
        ex_we_i = 0; lsu_we_i = 0;
        for (int k = 0; k < 12; k++) begin
            mc_waddr_i = AW'(20 + k); mc_wdata_i = 32'h400 + 4 + k;
            settle();
            chk("t4_ready", mc_ready_o, 1);
            chk("t4_cnt", fifo_cnt_o, 4);
            chk("t4_waddr_b", waddr_b_o, 16 + k);
            step();
        end
        mc_valid_i = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t4_tail_b", waddr_b_o, 28 + k);
            step();
        end
        settle();
        chk("t4_empty", fifo_cnt_o, 0);
        idle_inputs(); step();

        // 5: two entries to x12 keep pending[12] until the last one drains
        ex_we_i = 1; lsu_we_i = 1; mc_valid_i = 1; mc_waddr_i = 12; mc_wdata_i = 1;
        step();
        mc_wdata_i = 2;
        step();
        mc_valid_i = 0; lsu_we_i = 0;
        settle();
        chk("t5_cnt2", fifo_cnt_o, 2);
        chk("t5_pend_a", pending_o, 64'h1000);
        chk("t5_data1", wdata_b_o, 1);
        step(); settle();
        chk("t5_cnt1", fifo_cnt_o, 1);
        chk("t5_pend_b", pending_o[12], 1);
        chk("t5_data2", wdata_b_o, 2);
        step(); settle();
        chk("t5_pend_c", pending_o, 0);
        idle_inputs(); step();

        // 6: setback flushes the FIFO and blocks writes/handshake
        ex_we_i = 1; lsu_we_i = 1;
        for (int i = 0; i < 3; i++) begin
            mc_valid_i = 1; mc_waddr_i = AW'(4 + i); mc_wdata_i = 32'h60 + i;
            step();
        end
        mc_waddr_i = 7; setback_i = 1;
        settle();
        chk("t6_we_a", we_a_o, 0);
        chk("t6_we_b", we_b_o, 0);
        chk("t6_ready", mc_ready_o, 0);
        step();
        idle_inputs();
        settle();
        chk("t6_cnt", fifo_cnt_o, 0);
        chk("t6_pending", pending_o, 0);
        step();
        mc_valid_i = 1; mc_waddr_i = 9; mc_wdata_i = 32'h99;
        settle();
`ifdef RF_WB_BYPASS_EN
        chk("t6_byp_we_b", we_b_o, 1);
        chk("t6_byp_waddr_b", waddr_b_o, 9);
        chk("t6_byp_ready", mc_ready_o, 1);
        step();
        mc_valid_i = 0;
        settle();
        chk("t6_byp_cnt", fifo_cnt_o, 0);
`else
        chk("t6_nb_we_b", we_b_o, 0);
        chk("t6_nb_ready", mc_ready_o, 1);
        step();
        mc_valid_i = 0;
        settle();
        chk("t6_nb_cnt", fifo_cnt_o, 1);
        chk("t6_nb_waddr_b", waddr_b_o, 9);
        step(); settle();
        chk("t6_nb_cnt0", fifo_cnt_o, 0);
`endif
        idle_inputs(); step();

        // 7: asynchronous reset mid-operation drops buffered entries
        ex_we_i = 1; lsu_we_i = 1; mc_valid_i = 1; mc_waddr_i = 20; mc_wdata_i = 5;
        step(); step();
        mc_valid_i = 0;
        #1 rst_n = 0;
        #1;
        chk("t7_rst_cnt", fifo_cnt_o, 0);
        chk("t7_rst_pend", pending_o, 0);
        step();
        rst_n = 1;
        idle_inputs();
        settle();
        chk("t7_after_cnt", fifo_cnt_o, 0);
        chk("t7_after_we_b", we_b_o, 0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
